// File: rtl/display_mux_n_if.sv
// display_mux_n_if: value/control inputs and display pin outputs of the 7-segment scanner
interface display_mux_n_if #(
    parameter int NDIGITS = 8
);
    logic [4*NDIGITS-1:0] val;
    logic [NDIGITS-1:0]   dp_in;
    logic [NDIGITS-1:0]   digit_en;
    logic [3:0]           brightness;
    logic [7:0]           segments;
    logic [7:0]           digitselect;
    modport master (output val, dp_in, digit_en, brightness, input segments, digitselect);
    modport slave (input val, dp_in, digit_en, brightness, output segments, digitselect);
endinterface

// File: rtl/display_mux_n.sv
// display_mux_n: multiplexed common-anode 7-segment driver; define LEADING_ZERO_BLANK_EN to blank leading zeros
module display_mux_n #(
    parameter int NDIGITS      = 8,
    parameter int DIV_BITS     = 17,
    parameter int BLANK_CYCLES = 256
) (
    input  logic           clk,
    input  logic           reset_n,
    display_mux_n_if.slave bus
);
    localparam logic [DIV_BITS-1:0] BLANK = DIV_BITS'(BLANK_CYCLES);
    localparam logic [2:0] LAST = 3'(NDIGITS - 1);
    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    logic [DIV_BITS-1:0]  prescaler;
    logic [2:0]           idx;
    logic [4*NDIGITS-1:0] val_q;
    logic [NDIGITS-1:0]   dp_q;
    logic                 tick, on, lz, show, dp;
    logic [3:0]           nib;
    logic [7:0]           en8, seg_d, sel_d;
    assign tick = &prescaler;
    assign en8  = 8'(bus.digit_en);
    assign nib  = 4'(32'(val_q) >> {idx, 2'b00});
    assign dp   = 1'(8'(dp_q) >> idx);
    assign on   = prescaler >= BLANK && prescaler[DIV_BITS-1 -: 4] <= bus.brightness && en8[idx];
`ifdef LEADING_ZERO_BLANK_EN
    assign lz   = idx != 3'd0 && (val_q >> {idx, 2'b00}) == '0;
`else
    assign lz   = 1'b0;
`endif
    assign show = on && !(lz && !dp);
    // Next pin values for the current slot, registered below so select and segments switch together
    always_comb begin
        sel_d = show ? ~(8'b1 << idx) : 8'hFF;
        seg_d = !show ? 8'hFF : lz ? 8'h7F : {~dp, GLYPH[nib][6:0]};
    end
    // Prescaler, digit scan, frame latch at the last digit's tick, and registered pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler       <= '0;
            idx             <= 3'd0;
            val_q           <= '0;
            dp_q            <= '0;
            bus.segments    <= 8'hFF;
            bus.digitselect <= 8'hFF;
        end else begin
            prescaler       <= prescaler + DIV_BITS'(1);
            if (tick)
                idx <= idx == LAST ? 3'd0 : idx + 3'd1;
            if (tick && idx == LAST) begin
                val_q <= bus.val;
                dp_q  <= bus.dp_in;
            end
            bus.segments    <= seg_d;
            bus.digitselect <= sel_d;
        end
    end
endmodule
